// File: rtl/run_mon_pkg.sv
// Shared types and helpers for the run monitor: FSM state encoding and saturating increment.
package run_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } run_state_t;

    // Increment that sticks at the all-ones value of a counter 'width' bits wide.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/rv32_run_monitor_if.sv
// Control, core-status and result signals of the run monitor.
// RUN_MON_SIGNATURE_EN adds the signature result signal.
interface rv32_run_monitor_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             clear;
    logic             core_stall;
    logic             core_flush;
    logic             core_halt;
    logic [31:0]      core_wb_result;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] retire_count;
    logic [31:0]      final_result;
`ifdef RUN_MON_SIGNATURE_EN
    logic [31:0]      signature;
`endif

    modport master (
        output start, clear, core_stall, core_flush, core_halt, core_wb_result,
        input  busy, done, timeout, cycle_count, stall_count, flush_count,
               retire_count, final_result
`ifdef RUN_MON_SIGNATURE_EN
        , input signature
`endif
    );

    modport slave (
        input  start, clear, core_stall, core_flush, core_halt, core_wb_result,
        output busy, done, timeout, cycle_count, stall_count, flush_count,
               retire_count, final_result
`ifdef RUN_MON_SIGNATURE_EN
        , output signature
`endif
    );
endinterface

// File: rtl/run_mon_sat_counter.sv
// Saturating event counter with synchronous clear; never wraps past all-ones.
module run_mon_sat_counter
    import run_mon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_next;

    assign count_next = CNT_W'(sat_inc(64'(count), CNT_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count_next;
        end
    end
endmodule

// File: rtl/rv32_run_monitor.sv
// Run monitor: measures one program run from start to core halt or watchdog expiry.
// Optional RUN_MON_SIGNATURE_EN folds every retired writeback value into a signature.
//
// state   | meaning
// IDLE    | waiting for start, all results zero
// RUN     | counting core activity
// DONE    | core halted, results frozen
// TIMEOUT | watchdog expired, results frozen
module rv32_run_monitor
    import run_mon_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32_run_monitor_if.slave    bus
);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    run_state_t       state;
    run_state_t       state_next;
    logic             count_en;
    logic             retire_en;
    logic             wd_fire;
    logic [31:0]      final_result;
    logic [CNT_W-1:0] cycle_count;

    // Halt freezes the counters on its own edge, so only non-halt RUN cycles count.
    assign count_en  = (state == RUN) && !bus.core_halt && !bus.clear;
    assign retire_en = count_en && !bus.core_stall && !bus.core_flush;
    assign wd_fire   = (TIMEOUT_CYCLES != 0) && (cycle_count == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_next = RUN;
                RUN: begin
                    if (bus.core_halt)  state_next = DONE;
                    else if (wd_fire)   state_next = TIMEOUT;
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            final_result <= '0;
        end else if (bus.clear) begin
            final_result <= '0;
        end else if ((state == RUN) && bus.core_halt) begin
            final_result <= bus.core_wb_result;
        end
    end

    run_mon_sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk(clk), .rst(rst), .inc(count_en), .clr(bus.clear), .count(cycle_count)
    );
    run_mon_sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk(clk), .rst(rst), .inc(count_en && bus.core_stall), .clr(bus.clear),
        .count(bus.stall_count)
    );
    run_mon_sat_counter #(.CNT_W(CNT_W)) u_flush (
        .clk(clk), .rst(rst), .inc(count_en && bus.core_flush), .clr(bus.clear),
        .count(bus.flush_count)
    );
    run_mon_sat_counter #(.CNT_W(CNT_W)) u_retire (
        .clk(clk), .rst(rst), .inc(retire_en), .clr(bus.clear), .count(bus.retire_count)
    );

`ifdef RUN_MON_SIGNATURE_EN
    logic [31:0] signature;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signature <= '0;
        end else if (bus.clear) begin
            signature <= '0;
        end else if (retire_en) begin
            signature <= {signature[30:0], signature[31]} ^ bus.core_wb_result;
        end
    end

    assign bus.signature = signature;
`endif

    assign bus.busy         = (state == RUN);
    assign bus.done         = (state == DONE);
    assign bus.timeout      = (state == TIMEOUT);
    assign bus.cycle_count  = cycle_count;
    assign bus.final_result = final_result;
endmodule
